// File: rtl/fp_add_arbiter_pkg.sv
// rtl/fp_add_arbiter_pkg.sv - shared types and width helpers for the adder arbiter
// State encoding plus word/index width derivations used by the top and the picker.
package fpaddarbpkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } StateType;

   function automatic int word_width(input int expbits, input int mantbits);
      return 1 + expbits + mantbits;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fp_add_arbiter_rr_picker.sv
// rtl/fp_add_arbiter_rr_picker.sv - combinational round-robin winner select
// Scans upward from the pointer with wrap; first valid requester wins.
module rr_picker import fpaddarbpkg::*; #(
   parameter int NREQ = 4,
   parameter int IDXW = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [IDXW-1:0] ptr_i,
   output logic [NREQ-1:0] winner_o,
   output logic            any_o
);

   always_comb begin
      int idx;
      idx      = 0;
      winner_o = '0;
      any_o    = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_i) + k) % NREQ;
         if (!any_o && valid_i[IDXW'(idx)]) begin
            winner_o[IDXW'(idx)] = 1'b1;
            any_o                = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - shares one floating-point adder among NREQ requesters
// One operation in flight: grant, issue, wait for done (with timeout), respond.
module fp_add_arbiter import fpaddarbpkg::*; #(
   parameter int  NREQ         = 4,
   parameter int  EXPBITS      = 8,
   parameter int  MANTISSABITS = 23,
   parameter int  TIMEOUT      = 64,
   localparam int W            = word_width(EXPBITS, MANTISSABITS)
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [NREQ-1:0]   ReqValid,
   input  logic [NREQ*W-1:0] ReqA,
   input  logic [NREQ*W-1:0] ReqB,
   output logic [NREQ-1:0]   ReqGrant,
   output logic              AdderGo,
   output logic [W-1:0]      AdderA,
   output logic [W-1:0]      AdderB,
   input  logic              AdderDone,
   input  logic [W-1:0]      AdderResult,
   output logic [NREQ-1:0]   RespValid,
   output logic [W-1:0]      RespResult,
   input  logic              RespReady,
   output logic              TimeoutErr
);

   localparam int              IDXW     = idx_width(NREQ);
   localparam int              CNTW     = $clog2(TIMEOUT) + 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREQ - 1);

   StateType        state_q, state_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [IDXW-1:0] owner_q, owner_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    res_q, res_d;
   logic            tout_q, tout_d;

   logic [NREQ-1:0] winner;
   logic            any_valid;
   logic [IDXW-1:0] win_idx;

   rr_picker #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_picker (
      .valid_i  (ReqValid),
      .ptr_i    (ptr_q),
      .winner_o (winner),
      .any_o    (any_valid)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner[i]) begin
            win_idx = IDXW'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      tout_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               owner_d = win_idx;
               ptr_d   = (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
               a_d     = ReqA[int'(win_idx)*W +: W];
               b_d     = ReqB[int'(win_idx)*W +: W];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // Done takes priority over a timeout landing in the same cycle.
            if (AdderDone) begin
               res_d   = AdderResult;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               tout_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (RespReady) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         tout_q  <= tout_d;
      end
   end

   // Grant is gated by Reset so nothing is accepted while reset is held.
   assign ReqGrant   = (state_q == IDLE && !Reset) ? winner : '0;
   assign AdderGo    = (state_q == ISSUE);
   assign AdderA     = a_q;
   assign AdderB     = b_q;
   assign RespResult = res_q;
   assign TimeoutErr = tout_q;

   always_comb begin
      RespValid = '0;
      if (state_q == RESP) begin
         RespValid[owner_q] = 1'b1;
      end
   end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - directed self-checking bench for fp_add_arbiter
module tb_fp_add_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 32;

   logic              Clock = 1'b0;
   logic              Reset = 1'b1;
   logic [NREQ-1:0]   ReqValid = '0;
   logic [NREQ*W-1:0] ReqA = '0;
   logic [NREQ*W-1:0] ReqB = '0;
   logic [NREQ-1:0]   ReqGrant;
   logic              AdderGo;
   logic [W-1:0]      AdderA;
   logic [W-1:0]      AdderB;
   logic              AdderDone = 1'b0;
   logic [W-1:0]      AdderResult = '0;
   logic [NREQ-1:0]   RespValid;
   logic [W-1:0]      RespResult;
   logic              RespReady = 1'b1;
   logic              TimeoutErr;

   int checks = 0;
   int errors = 0;

   int   done_delay = 1;
   int   dcnt = -1;
   logic kick = 1'b0;

   int cyc = 0;
   int go_cnt = 0;
   int tout_cnt = 0;
   int resp_cnt = 0;
   int go_cyc = 0;
   int tout_cyc = 0;
   int glog[$];

   always #5 Clock = ~Clock;

   fp_add_arbiter dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .ReqValid    (ReqValid),
      .ReqA        (ReqA),
      .ReqB        (ReqB),
      .ReqGrant    (ReqGrant),
      .AdderGo     (AdderGo),
      .AdderA      (AdderA),
      .AdderB      (AdderB),
      .AdderDone   (AdderDone),
      .AdderResult (AdderResult),
      .RespValid   (RespValid),
      .RespResult  (RespResult),
      .RespReady   (RespReady),
      .TimeoutErr  (TimeoutErr)
   );

   function automatic logic [W-1:0] fp_sum(input logic [W-1:0] a, input logic [W-1:0] b);
      case ({a, b})
         {32'h3F800000, 32'h40000000}: return 32'h40400000;
         {32'h3FC00000, 32'h40200000}: return 32'h40800000;
         {32'h3F000000, 32'h3E800000}: return 32'h3F400000;
         default:                      return 32'hDEADBEEF;
      endcase
   endfunction

   // Adder model: Done pulses done_delay cycles after the Go cycle (-1 = never).
   always @(negedge Clock) begin
      AdderDone = 1'b0;
      if (Reset) dcnt = -1;
      else if (AdderGo) dcnt = done_delay;
      else if (dcnt > 0) dcnt = dcnt - 1;
      if (!Reset && (kick || dcnt == 0)) begin
         AdderDone   = 1'b1;
         AdderResult = fp_sum(AdderA, AdderB);
      end
      if (dcnt == 0) dcnt = -1;
   end

   always @(posedge Clock) cyc <= cyc + 1;

   always @(negedge Clock) begin
      if (AdderGo) begin
         go_cnt++;
         go_cyc = cyc;
      end
      if (TimeoutErr) begin
         tout_cnt++;
         tout_cyc = cyc;
      end
      if (RespValid != '0) resp_cnt++;
      for (int i = 0; i < NREQ; i++) begin
         if (ReqGrant[i]) glog.push_back(i);
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      Reset     = 1'b1;
      ReqValid  = '0;
      RespReady = 1'b1;
      kick      = 1'b0;
      repeat (2) tick();
      Reset = 1'b0;
      glog.delete();
      go_cnt   = 0;
      tout_cnt = 0;
      resp_cnt = 0;
   endtask

   task automatic issue(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, output int n);
      ReqA[idx*W +: W] = a;
      ReqB[idx*W +: W] = b;
      ReqValid[idx]    = 1'b1;
      n = 0;
      #1;
      while (!ReqGrant[idx] && n < 50) begin
         tick();
         n++;
      end
      chk("grant_wait", n < 50, 1);
      tick();
      ReqValid[idx] = 1'b0;
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      while (RespValid == '0 && n < 200) begin
         tick();
         n++;
      end
      chk("resp_wait", n < 200, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n;
      int exp_rr[5];
      exp_rr = '{0, 1, 2, 3, 0};

      // Reset state, with requests pending to confirm no grant during reset
      ReqValid = '1;
      repeat (3) tick();
      chk("rst_grant", ReqGrant, 0);
      chk("rst_go", AdderGo, 0);
      chk("rst_respv", RespValid, 0);
      chk("rst_tout", TimeoutErr, 0);
      chk("rst_a", AdderA, 0);
      chk("rst_b", AdderB, 0);
      chk("rst_res", RespResult, 0);

      // Single operation 1.0 + 2.0
      do_reset();
      done_delay = 3;
      issue(0, 32'h3F800000, 32'h40000000, n);
      chk("single_grant", glog.size() == 1 && glog[0] == 0, 1);
      chk("single_go", AdderGo, 1);
      chk("single_a", AdderA, 32'h3F800000);
      chk("single_b", AdderB, 32'h40000000);
      wait_resp(n);
      chk("single_lat", n, 4);
      chk("single_respv", RespValid, 4'b0001);
      chk("single_res", RespResult, 32'h40400000);
      chk("single_gocnt", go_cnt, 1);
      tick();
      chk("single_release", RespValid, 0);
      chk("single_idle_go", AdderGo, 0);

      // Round-robin fairness with all requesters continuously valid
      do_reset();
      done_delay = 1;
      ReqValid   = '1;
      n = 0;
      while (glog.size() < 5 && n < 100) begin
         tick();
         n++;
      end
      ReqValid = '0;
      chk("rr_count", glog.size() >= 5, 1);
      for (int i = 0; i < 5 && i < glog.size(); i++) begin
         chk($sformatf("rr_order%0d", i), glog[i], exp_rr[i]);
      end

      // Response held 10 cycles: stable result, no new grant meanwhile
      do_reset();
      RespReady  = 1'b0;
      done_delay = 2;
      issue(2, 32'h3FC00000, 32'h40200000, n);
      ReqValid[2] = 1'b1;
      ReqValid[1] = 1'b1;
      wait_resp(n);
      for (int i = 0; i < 10; i++) begin
         chk("hold_respv", RespValid, 4'b0100);
         chk("hold_res", RespResult, 32'h40800000);
         tick();
      end
      chk("hold_nogrant", glog.size(), 1);
      RespReady = 1'b1;
      tick();
      chk("hold_release", RespValid, 0);
      chk("hold_next_grant", ReqGrant, 4'b0010);
      ReqValid = '0;

      // Timeout: adder never answers
      do_reset();
      done_delay = -1;
      ReqA[1*W +: W] = 32'h3F800000;
      ReqB[1*W +: W] = 32'h40000000;
      ReqValid[1]    = 1'b1;
      issue(0, 32'h3F000000, 32'h3E800000, n);
      ReqValid[0] = 1'b1;
      n = 0;
      while (tout_cnt == 0 && n < 150) begin
         tick();
         n++;
      end
      chk("tout_seen", tout_cnt, 1);
      chk("tout_delay", tout_cyc - (go_cyc + 1), 64);
      chk("tout_noresp", resp_cnt, 0);
      chk("tout_next_grant", glog.size() >= 2 && glog[1] == 1, 1);
      repeat (3) tick();
      chk("tout_pulse", tout_cnt, 1);
      ReqValid = '0;

      // Done on the final WAIT cycle wins over timeout
      do_reset();
      done_delay = 64;
      issue(3, 32'h3F000000, 32'h3E800000, n);
      wait_resp(n);
      chk("last_lat", n, 65);
      chk("last_respv", RespValid, 4'b1000);
      chk("last_res", RespResult, 32'h3F400000);
      repeat (3) tick();
      chk("last_notout", tout_cnt, 0);

      // Reset during WAIT, then a stray Done
      do_reset();
      done_delay = -1;
      issue(1, 32'h3F800000, 32'h40000000, n);
      repeat (5) tick();
      Reset = 1'b1;
      repeat (2) tick();
      Reset = 1'b0;
      kick  = 1'b1;
      tick();
      kick = 1'b0;
      repeat (8) tick();
      chk("mid_grant", ReqGrant, 0);
      chk("mid_go", AdderGo, 0);
      chk("mid_respv", RespValid, 0);
      chk("mid_tout", TimeoutErr, 0);
      chk("mid_a", AdderA, 0);
      chk("mid_b", AdderB, 0);
      chk("mid_res", RespResult, 0);
      chk("mid_noresp", resp_cnt, 0);
      chk("mid_gocnt", go_cnt, 1);
      chk("mid_glog", glog.size(), 1);
      done_delay = 1;
      issue(2, 32'h3F800000, 32'h40000000, n);
      chk("mid_idle_grant", n, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one adder.
REQ-002 Parameter EXPBITS, default 8: exponent width.
REQ-003 Parameter MANTISSABITS, default 23: mantissa width; W = 1+EXPBITS+MANTISSABITS.
REQ-004 Parameter TIMEOUT, default 64: maximum WAIT cycles before abort.
REQ-005 Clock  in  1  single clock; all state updates on posedge Clock.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 ReqValid  in  NREQ  per-requester request.
REQ-008 ReqA, ReqB  in  NREQ*W each  flattened operand vectors; slice i belongs to requester i.
REQ-009 ReqGrant  out  NREQ  one-hot accept strobe.
REQ-010 AdderGo  out  1  start strobe to the adder.
REQ-011 AdderA, AdderB  out  W each  latched operands to the adder.
REQ-012 AdderDone  in  1  adder result-valid pulse.
REQ-013 AdderResult  in  W  adder sum.
REQ-014 RespValid  out  NREQ  one-hot response-valid flag.
REQ-015 RespResult  out  W  latched sum.
REQ-016 RespReady  in  1  response consumed by the owning requester.
REQ-017 TimeoutErr  out  1  one-cycle abort pulse.

Function
REQ-018 FSM states are IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE, with any ReqValid high: pick the winner round-robin, searching upward from pointer Ptr with wrap.
REQ-020 In that same IDLE cycle: ReqGrant[winner]=1, latch the winner's operands and index (Owner), set Ptr=(winner+1) mod NREQ, go to ISSUE.
REQ-021 IDLE with no ReqValid: stay in IDLE; ReqGrant=0.
REQ-022 A requester holds ReqValid and its operands stable until granted; deasserting before grant has no side effect.
REQ-023 ISSUE: AdderGo=1 for exactly this one cycle, then go to WAIT.
REQ-024 AdderA/AdderB show the latched operands throughout ISSUE and WAIT.
REQ-025 WAIT: cycle counter starts at 0 and increments every cycle; AdderDone is sampled only in WAIT.
REQ-026 WAIT with AdderDone: latch AdderResult into RespResult, go to RESP.
REQ-027 WAIT with counter==TIMEOUT-1 and no AdderDone: TimeoutErr=1 for one cycle, go to IDLE; the request is dropped.
REQ-028 AdderDone and timeout in the same cycle: AdderDone wins; no TimeoutErr.
REQ-029 RESP: RespValid[Owner]=1 and RespResult is held stable; on RespReady go to IDLE.
REQ-030 RespReady outside RESP is ignored.
REQ-031 Throughput: at most one operation in flight; minimum 4 cycles per operation (IDLE, ISSUE, one WAIT, RESP).
REQ-032 A requester re-asserting ReqValid while its own response is pending is not granted until IDLE.
REQ-033 The counter is $clog2(TIMEOUT)+1 bits wide and never wraps.

Reset
REQ-034 On Reset: State=IDLE, Ptr=0, Owner=0, counter=0.
REQ-035 On Reset: ReqGrant=0, AdderGo=0, RespValid=0, TimeoutErr=0, AdderA/AdderB/RespResult=0.
REQ-036 Reset asserted mid-operation aborts it; no grant, go or response follows, and AdderDone arriving afterward is ignored.

Structure
REQ-037 Package fpaddarbpkg holds the StateType enum {IDLE,ISSUE,WAIT,RESP} and the word-width constant derivation.
REQ-038 One combinational sub-module, rr_picker, takes ReqValid and Ptr and outputs the one-hot winner and an any-valid flag.
REQ-039 All outputs are decoded from registered state/Owner, except ReqGrant, which is IDLE-state decode of rr_picker.

Verification
REQ-040 Single op: requester 0 sends ReqA=0x3F800000 (1.0), ReqB=0x40000000 (2.0), adder model Done after 3 cycles -> ReqGrant=0001, one AdderGo, RespValid=0001, RespResult=0x40400000.
REQ-041 All four ReqValid high continuously from reset -> grant order 0,1,2,3,0; no requester granted twice before the others.
REQ-042 Adder never asserts Done, TIMEOUT=64 -> TimeoutErr pulse exactly 64 cycles after the WAIT entry, then IDLE, and the next requester is served.
REQ-043 AdderDone on the final WAIT cycle -> response delivered; TimeoutErr stays 0.
REQ-044 RespReady held low for 10 cycles -> RespValid and RespResult stable for 10 cycles, and no new grant during that time.
REQ-045 Reset asserted during WAIT, then Done pulsed -> all outputs 0, State=IDLE, no RespValid.
